// File: rtl/mostrar_fpga_pkg.sv
// mostrar_fpga_pkg: shared states and counter constants for the passage counter
package mostrar_fpga_pkg;
    localparam int CNT_W_DEF = 4;
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        IN1  = 3'd1,
        IN2  = 3'd2,
        IN3  = 3'd3,
        OUT1 = 3'd4,
        OUT2 = 3'd5,
        OUT3 = 3'd6
    } state_t;
endpackage

// File: rtl/mostrar_fpga_btn_sync.sv
// btn_sync: multi-flop synchroniser for one asynchronous button level
module btn_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] sr;
    // shift the pin level through the chain, cleared on reset
    always_ff @(posedge CLK) begin
        if (RST) sr <= '0;
        else     sr <= {sr[SYNC_STAGES-2:0], d};
    end
    assign q = sr[SYNC_STAGES-1];
endmodule

// File: rtl/mostrar_fpga.sv
// mostrar_fpga: bidirectional passage counter, two beam sensors in, count on LEDs
module mostrar_fpga
    import mostrar_fpga_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN1,
    input  logic BTN4,
    output logic LED0,
    output logic LED1,
    output logic LED2,
    output logic LED3
);
    logic a, b, inc, dec;
    logic [CNT_W-1:0] count;
    state_t state, nxt;

    btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (.CLK(CLK), .RST(RST), .d(BTN1), .q(a));
    btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (.CLK(CLK), .RST(RST), .d(BTN4), .q(b));

    // state register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= nxt;
    end

    // sequence decoder: entry is A,AB,B,none; exit is the mirror image
    always_comb begin
        nxt = state;
        inc = 1'b0;
        dec = 1'b0;
        case (state)
            IDLE: nxt = ({a, b} == 2'b10) ? IN1 : ({a, b} == 2'b01) ? OUT1 : IDLE;
            IN1:  nxt = ({a, b} == 2'b10) ? IN1 : ({a, b} == 2'b11) ? IN2 : IDLE;
            IN2:  nxt = ({a, b} == 2'b11) ? IN2 : ({a, b} == 2'b01) ? IN3 :
                        ({a, b} == 2'b10) ? IN1 : IDLE;
            IN3: begin
                nxt = ({a, b} == 2'b01) ? IN3 : ({a, b} == 2'b11) ? IN2 : IDLE;
                inc = ({a, b} == 2'b00);
            end
            OUT1: nxt = ({a, b} == 2'b01) ? OUT1 : ({a, b} == 2'b11) ? OUT2 : IDLE;
            OUT2: nxt = ({a, b} == 2'b11) ? OUT2 : ({a, b} == 2'b10) ? OUT3 :
                        ({a, b} == 2'b01) ? OUT1 : IDLE;
            OUT3: begin
                nxt = ({a, b} == 2'b10) ? OUT3 : ({a, b} == 2'b11) ? OUT2 : IDLE;
                dec = ({a, b} == 2'b00);
            end
            default: nxt = IDLE;
        endcase
    end

    // saturating up/down counter, updated on the completing transition
    always_ff @(posedge CLK) begin
        if (RST)                       count <= '0;
        else if (inc && count != '1)   count <= count + 1'b1;
        else if (dec && count != '0)   count <= count - 1'b1;
    end

    assign {LED3, LED2, LED1, LED0} = count[3:0];
endmodule

// File: tb/tb_mostrar_fpga.sv
// tb_mostrar_fpga: directed checks of entry/exit counting, aborts, saturation, reset
module tb_mostrar_fpga;
    import mostrar_fpga_pkg::*;
    logic clk = 1'b0, rst = 1'b1, btn1 = 1'b0, btn4 = 1'b0;
    logic led0, led1, led2, led3;
    int checks = 0, errors = 0;

    mostrar_fpga dut (
        .CLK(clk), .RST(rst), .BTN1(btn1), .BTN4(btn4),
        .LED0(led0), .LED1(led1), .LED2(led2), .LED3(led3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] leds();
        return {led3, led2, led1, led0};
    endfunction

    task automatic pins(input logic a, input logic b, input int n);
        btn1 = a;
        btn4 = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic entry();
        pins(1, 0, 3); pins(1, 1, 3); pins(0, 1, 3); pins(0, 0, 4);
    endtask

    task automatic exit_seq();
        pins(0, 1, 3); pins(1, 1, 3); pins(1, 0, 3); pins(0, 0, 4);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pins(0, 0, 2);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        chk("reset_leds", leds(), 4'b0000);
        chk("reset_state", {1'b0, dut.state}, {1'b0, IDLE});

        pins(1, 0, 2); pins(1, 1, 2); pins(0, 1, 2); pins(0, 0, 2);
        chk("entry_not_yet", leds(), 4'b0000);
        pins(0, 0, 1);
        chk("entry_3rd_edge", leds(), 4'b0001);
        pins(0, 0, 2);

        for (int i = 2; i <= 7; i++) begin
            entry();
            chk("entry_n", leds(), 4'(i));
        end
        for (int i = 6; i >= 0; i--) begin
            exit_seq();
            chk("exit_n", leds(), 4'(i));
        end

        entry();
        chk("pre_abort", leds(), 4'b0001);
        pins(1, 0, 3); pins(1, 1, 3); pins(1, 0, 3); pins(0, 0, 4);
        chk("abort_entry", leds(), 4'b0001);
        pins(0, 1, 3); pins(1, 1, 3); pins(0, 1, 3); pins(0, 0, 4);
        chk("abort_exit", leds(), 4'b0001);

        do_reset();
        chk("sat_start", leds(), 4'b0000);
        for (int i = 1; i <= 16; i++) begin
            entry();
            chk("sat_up", leds(), (i > 15) ? 4'd15 : 4'(i));
        end
        exit_seq();
        chk("sat_top_exit", leds(), 4'd14);

        do_reset();
        exit_seq();
        chk("exit_at_zero", leds(), 4'b0000);
        chk("zero_state", {1'b0, dut.state}, {1'b0, IDLE});

        entry();
        chk("pre_midreset", leds(), 4'b0001);
        pins(1, 0, 3); pins(1, 1, 3);
        rst = 1'b1;
        pins(1, 1, 1);
        rst = 1'b0;
        chk("midreset_clear", leds(), 4'b0000);
        pins(0, 1, 3); pins(0, 0, 4);
        chk("midreset_no_inc", leds(), 4'b0000);
        entry();
        chk("after_midreset", leds(), 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mostrar_fpga.md
Name: mostrar_fpga

Overview:
- Bidirectional passage counter for the FPGA board demo.
- Two sensor inputs, BTN1 (sensor A, outer) and BTN4 (sensor B, inner), are synchronised and decoded by a quadrature-style FSM.
- A complete A→AB→B→none sequence is one entry (count +1). The reverse, B→AB→A→none, is one exit (count −1).
- The 4-bit count drives LED0..LED3 directly. The block is the top level: board pins in, LEDs out.

Parameters:
- CNT_W, 4: counter/LED width; saturation limit is 2^CNT_W−1 = 15.
- SYNC_STAGES, 2: flip-flop stages per button input synchroniser (≥2).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- BTN1 in  1  sensor A, asynchronous level, 1 = beam blocked / pressed.
- BTN4 in  1  sensor B, asynchronous level, 1 = blocked.
- LED0 out 1  count[0] (LSB).
- LED1 out 1  count[1].
- LED2 out 1  count[2].
- LED3 out 1  count[3] (MSB).

Behaviour:
- One clock (CLK); reset RST is synchronous, active-high. While RST is sampled 1, all registers are cleared:
  - synchroniser flops = 0
  - FSM = IDLE
  - count = 0, so LED0..LED3 = 0.
- Synchroniser: BTN1 and BTN4 each pass through a SYNC_STAGES flop chain. The FSM uses only the last-stage values a (from BTN1) and b (from BTN4).
- No debounce filter. Each pin level must be stable for at least 1 clock to be seen. The input-to-FSM delay is SYNC_STAGES cycles.
- FSM states: IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3. Input written as {a,b}.
- IDLE:
  - 10→IN1
  - 01→OUT1
  - 00/11→stay
- IN1:
  - 10 stay
  - 11→IN2
  - 00 or 01→IDLE (aborted)
- IN2:
  - 11 stay
  - 01→IN3
  - 10→IN1 (backed off)
  - 00→IDLE
- IN3:
  - 01 stay
  - 00→IDLE and increment
  - 11→IN2
  - 10→IDLE
- OUT1:
  - 01 stay
  - 11→OUT2
  - 00 or 10→IDLE
- OUT2:
  - 11 stay
  - 10→OUT3
  - 01→OUT1
  - 00→IDLE
- OUT3:
  - 10 stay
  - 00→IDLE and decrement
  - 11→OUT2
  - 01→IDLE
- Count update:
  - Registered on the same edge as the IN3/OUT3→IDLE transition.
  - With SYNC_STAGES=2, LEDs change on the 3rd rising edge after the pins return to 00.
- Saturation:
  - Increment at 15 keeps 15.
  - Decrement at 0 keeps 0. No wrap-around.
  - The FSM still returns to IDLE in both cases.
- Increment and decrement are mutually exclusive by construction; at most one count change per completed sequence.
- LEDs are driven straight from the count register; no extra pipeline stage.
- RST asserted mid-sequence: the partial sequence is discarded and the count is cleared. After release, the next sequence starts from IDLE.

Decomposition:
- Shared package mostrar_fpga_pkg:
  - state enum with IDLE=0, IN1..IN3, OUT1..OUT3; 3-bit encoding
  - CNT_W default
  - CNT_MAX constant.
- One natural sub-module: btn_sync (parameter SYNC_STAGES; ports CLK, RST, d, q), instantiated twice.
- FSM and counter stay in mostrar_fpga.

Test Plan:
- Reset: RST=1 for 2 cycles, pins 00 → LED3..0=0000 and FSM IDLE after release.
- One entry, each step held ≥2 cycles (BTN1,BTN4 = 10,11,01,00) → LEDs=0001 within 3 cycles of the final 00.
- Seven entries → LEDs=0111. Then seven exits (01,11,10,00) → LEDs step down to 0000, one decrement per sequence.
- Aborted entry: 10,11,10,00 → count unchanged. Then 01,11,01,00 (exit aborted back at OUT2→OUT1) → unchanged.
- Saturation:
  - 16 entries from 0 → LEDs=1111 after the 15th and remain 1111.
  - An exit at count 0 → stays 0000.
- Reset mid-sequence: after 10,11, assert RST one cycle, then 01,00 → count 0 and no increment; a following full entry → 0001.
